// File: rtl/granule_pkg.sv
// Shared constants and types for the granule streamer: sample geometry,
// the stereo sample record and the read-side state encoding.
package granule_pkg;

    localparam int GRANULE_LEN = 576;
    localparam int SAMPLE_W    = 32;
    localparam int POS_W       = 10;

    typedef struct packed {
        logic [SAMPLE_W-1:0] ch1;
        logic [SAMPLE_W-1:0] ch2;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/granule_skid.sv
// Two-entry valid/ready skid buffer with a registered head; the producer
// throttles itself from `level`, so a push is never offered when both entries are busy.
module granule_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_v,
    input  logic [W-1:0] in_data,
    output logic         out_v,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   level
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_s;

    assign pop_s    = (cnt_q != 2'd0) && out_ready;
    assign out_v    = (cnt_q != 2'd0);
    assign out_data = head_q;
    assign level    = cnt_q;

    // Entry bookkeeping: head only moves on a pop or when the buffer is empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (in_v) begin
                    head_d = in_data;
                    cnt_d  = 2'd1;
                end else begin
                    cnt_d  = 2'd0;
                end
            end
            2'd1: begin
                if (in_v && pop_s) begin
                    head_d = in_data;
                end else if (in_v) begin
                    tail_d = in_data;
                    cnt_d  = 2'd2;
                end else if (pop_s) begin
                    cnt_d  = 2'd0;
                end else begin
                    cnt_d  = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_d = tail_q;
                    if (in_v) begin
                        tail_d = in_data;
                    end else begin
                        cnt_d  = 2'd1;
                    end
                end else begin
                    cnt_d = 2'd2;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/granule_streamer.sv
// Double-buffered granule store: position-addressed stereo writes in, in-order
// back-pressured stream out. Optional GRANULE_ZERO_FILL_EN streams unwritten positions as zero.
module granule_streamer
    import granule_pkg::*;
#(
    parameter int GRANULE_LEN = granule_pkg::GRANULE_LEN,
    parameter int SAMPLE_W    = granule_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] ch1_in,
    input  logic [SAMPLE_W-1:0] ch2_in,
    input  logic [POS_W-1:0]    wr_pos_in,
    input  logic                wr_v,
    input  logic                wr_commit,
    output logic                wr_ready,
    output logic [SAMPLE_W-1:0] ch1_out,
    output logic [SAMPLE_W-1:0] ch2_out,
    output logic [POS_W-1:0]    pos_out,
    output logic                dout_v,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                overflow
);

    localparam int ADDR_W = $clog2(2 * GRANULE_LEN);
    localparam int BEAT_W = 2 * SAMPLE_W + POS_W + 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(GRANULE_LEN - 1);

    // Both banks share one simple dual-port memory: bank b occupies [b*LEN, b*LEN+LEN).
    logic [2*SAMPLE_W-1:0] mem_q [0:2*GRANULE_LEN-1];
    logic [2*SAMPLE_W-1:0] rd_data_q;

    rd_state_e          state_q, state_d;
    logic [POS_W-1:0]   addr_q, addr_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               overflow_q, overflow_d;
    logic               rd_v_q, rd_v_d;
    logic [POS_W-1:0]   rd_pos_q, rd_pos_d;
    logic               rd_last_q, rd_last_d;

    logic               wr_ready_s, wr_acc_s, cm_acc_s;
    logic               issue_s, iss_bank_s, release_s, last_acc_s, pop_s, room_s;
    logic [2:0]         occ_s;
    logic [1:0]         skid_level_s;
    logic [ADDR_W-1:0]  wr_addr_s, rd_addr_s;
    logic [2*SAMPLE_W-1:0] smp_s;
    logic [BEAT_W-1:0]  skid_in_s, skid_out_s;

    assign wr_ready_s = !full_q[wr_bank_q];
    assign wr_acc_s   = wr_v && wr_ready_s && (wr_pos_in <= LAST_POS);
    assign cm_acc_s   = wr_commit && wr_ready_s;
    assign wr_addr_s  = wr_bank_q ? (ADDR_W'(GRANULE_LEN) + ADDR_W'(wr_pos_in)) : ADDR_W'(wr_pos_in);
    assign rd_addr_s  = iss_bank_s ? (ADDR_W'(GRANULE_LEN) + ADDR_W'(addr_q)) : ADDR_W'(addr_q);

    assign pop_s      = dout_v && dout_ready;
    assign last_acc_s = pop_s && dout_last;
    // Count the read already in flight so a stalled sink can never overrun the skid.
    assign occ_s      = {1'b0, skid_level_s} + {2'b00, rd_v_q} - {2'b00, pop_s};
    assign room_s     = (occ_s < 3'd2);

    // Read FSM, bank pointers and full flags. DRAIN prefetches the other bank
    // when it is already full so consecutive granules stream back to back.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        issue_s    = 1'b0;
        iss_bank_s = rd_bank_q;
        release_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q] && room_s) begin
                    issue_s = 1'b1;
                    addr_d  = addr_q + POS_W'(1);
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (room_s) begin
                    issue_s = 1'b1;
                    if (addr_q == LAST_POS) begin
                        addr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        addr_d  = addr_q + POS_W'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                iss_bank_s = ~rd_bank_q;
                if (full_q[~rd_bank_q] && room_s) begin
                    issue_s = 1'b1;
                    addr_d  = addr_q + POS_W'(1);
                end else begin
                    addr_d  = addr_q;
                end
                if (last_acc_s) begin
                    release_s = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = full_q[~rd_bank_q] ? STREAM : IDLE;
                end else begin
                    state_d   = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
        if (cm_acc_s) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end else begin
            wr_bank_d         = wr_bank_q;
        end
        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            rd_bank_d         = rd_bank_d;
        end
    end

    always_comb begin
        overflow_d = overflow_q | ((wr_v | wr_commit) & ~wr_ready_s);
        rd_v_d     = issue_s;
        rd_pos_d   = issue_s ? addr_q : rd_pos_q;
        rd_last_d  = issue_s ? (addr_q == LAST_POS) : rd_last_q;
    end

    // Control and read-pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
            rd_v_q     <= 1'b0;
            rd_pos_q   <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            overflow_q <= overflow_d;
            rd_v_q     <= rd_v_d;
            rd_pos_q   <= rd_pos_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Sample memory: contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_addr_s] <= {ch1_in, ch2_in};
        end
        if (issue_s) begin
            rd_data_q <= mem_q[rd_addr_s];
        end
    end

`ifdef GRANULE_ZERO_FILL_EN
    logic [1:0][GRANULE_LEN-1:0] mask_q, mask_d;
    logic                        rd_zero_q, rd_zero_d;

    // Written-position masks; a released bank starts its next fill with a clean mask.
    always_comb begin
        mask_d = mask_q;
        if (release_s) begin
            mask_d[rd_bank_q] = '0;
        end else begin
            mask_d[rd_bank_q] = mask_q[rd_bank_q];
        end
        if (wr_acc_s) begin
            mask_d[wr_bank_q][wr_pos_in] = 1'b1;
        end else begin
            mask_d[wr_bank_q] = mask_d[wr_bank_q];
        end
        rd_zero_d = issue_s ? !mask_q[iss_bank_s][addr_q] : rd_zero_q;
    end

    // Mask and zero-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            rd_zero_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    assign smp_s = rd_zero_q ? '0 : rd_data_q;
`else
    assign smp_s = rd_data_q;
`endif

    assign skid_in_s = {smp_s, rd_pos_q, rd_last_q};

    granule_skid #(.W(BEAT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_v      (rd_v_q),
        .in_data   (skid_in_s),
        .out_v     (dout_v),
        .out_data  (skid_out_s),
        .out_ready (dout_ready),
        .level     (skid_level_s)
    );

    assign ch1_out   = skid_out_s[BEAT_W-1 -: SAMPLE_W];
    assign ch2_out   = skid_out_s[POS_W+1 +: SAMPLE_W];
    assign pos_out   = skid_out_s[1 +: POS_W];
    assign dout_last = skid_out_s[0];
    assign wr_ready  = wr_ready_s;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_granule_streamer.sv
// Self-checking bench for granule_streamer: table-driven granules plus hand
// sequences, with a scoreboard queue filled at commit and drained by a monitor.
module tb_granule_streamer;

    localparam int N = 576;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ch1_in, ch2_in, ch1_out, ch2_out;
    logic [9:0]  wr_pos_in, pos_out;
    logic        wr_v, wr_commit, wr_ready, dout_v, dout_ready, dout_last, overflow;

    granule_streamer #(.GRANULE_LEN(N), .SAMPLE_W(32)) dut (
        .clk(clk), .rst(rst), .ch1_in(ch1_in), .ch2_in(ch2_in), .wr_pos_in(wr_pos_in),
        .wr_v(wr_v), .wr_commit(wr_commit), .wr_ready(wr_ready), .ch1_out(ch1_out),
        .ch2_out(ch2_out), .pos_out(pos_out), .dout_v(dout_v), .dout_ready(dout_ready),
        .dout_last(dout_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

`ifdef GRANULE_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] c1;
        logic [31:0] c2;
        logic [9:0]  pos;
        logic        last;
    } exp_t;

    typedef struct {
        bit          desc;
        logic [31:0] base;
        int          rmode;
        logic [31:0] exp0;
        logic [31:0] exp575;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [31:0] m1 [2][N];
    logic [31:0] m2 [2][N];
    bit          mw [2][N];
    int          mbank = 0;
    int          rmode = 0;
    longint      cyc = 0;
    longint      cmt_cyc = 0;
    longint      last_cyc = 0;
    int          gap = 0;
    int          beat_cnt = 0;
    bit          prev_last = 1'b0;
    logic [31:0] first_c1, last_c1;
    bit          held_v = 1'b0;
    logic [74:0] held;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = 1'b0;
        endcase
    end

    // Monitor: stall stability and in-order scoreboard comparison.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (held_v) chk("hold", {dout_v, ch1_out, ch2_out, pos_out, dout_last}, {1'b1, held});
            if (dout_v && dout_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got pos %0d want no beat", pos_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("beat", {ch1_out, ch2_out, pos_out, dout_last}, e);
                end
                if (pos_out == 10'd0) begin
                    first_c1 = ch1_out;
                    if (prev_last) gap = int'(cyc - last_cyc);
                end
                if (dout_last) begin
                    last_c1 = ch1_out;
                    last_cyc = cyc;
                end
                prev_last = dout_last;
                beat_cnt++;
            end
            held_v = dout_v && !dout_ready;
            held = {ch1_out, ch2_out, pos_out, dout_last};
        end
    end

    task automatic fill(input bit desc, input logic [31:0] base, input bit konst, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int p;
            logic [31:0] v;
            p = desc ? (cnt - 1 - i) : i;
            v = konst ? base : base + 32'(p);
            wr_v = 1'b1; wr_pos_in = 10'(p); ch1_in = v; ch2_in = ~v;
            m1[mbank][p] = v; m2[mbank][p] = ~v; mw[mbank][p] = 1'b1;
            @(posedge clk); #1;
        end
        wr_v = 1'b0;
    endtask

    task automatic commit_push();
        wr_commit = 1'b1;
        @(posedge clk); #1;
        wr_commit = 1'b0;
        cmt_cyc = cyc;
        for (int p = 0; p < N; p++) begin
            exp_t e;
            e.pos = 10'(p);
            e.last = (p == N - 1);
            if (mw[mbank][p] || !ZF) begin
                e.c1 = m1[mbank][p]; e.c2 = m2[mbank][p];
            end else begin
                e.c1 = 32'd0; e.c2 = 32'd0;
            end
            sb.push_back(e);
            mw[mbank][p] = 1'b0;
        end
        mbank ^= 1;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        chk("idle_dout_v", dout_v, 1'b0);
        @(posedge clk); #1;
    endtask

    vec_t tv[4];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i, start;
        tv[0] = '{1'b0, 32'h0000_0200, 1, 32'h0000_0200, 32'h0000_043F};
        tv[1] = '{1'b1, 32'h1234_0000, 0, 32'h1234_0000, 32'h1234_023F};
        tv[2] = '{1'b1, 32'hFFFF_FE00, 1, 32'hFFFF_FE00, 32'h0000_003F};
        tv[3] = '{1'b0, 32'h8000_0000, 1, 32'h8000_0000, 32'h8000_023F};

        rst = 1'b1; wr_v = 1'b0; wr_commit = 1'b0; wr_pos_in = 10'd0;
        ch1_in = 32'd0; ch2_in = 32'd0; dout_ready = 1'b1;
        @(negedge clk);
        chk("reset_outs", {dout_v, dout_last, ch1_out, ch2_out, pos_out, overflow, wr_ready},
            {1'b0, 1'b0, 32'd0, 32'd0, 10'd0, 1'b0, 1'b1});
        @(posedge clk); #1 rst = 1'b0;

        // In-order fill with commit latency and last-beat timing.
        fill(1'b0, 32'h0000_0100, 1'b0, N);
        commit_push();
        @(negedge clk); chk("lat_n1", {dout_v, wr_ready}, {1'b0, 1'b1});
        @(negedge clk); chk("lat_n2", dout_v, 1'b0);
        @(negedge clk); chk("lat_n3", {dout_v, pos_out, ch1_out}, {1'b1, 10'd0, 32'h100});
        wait_drain(3000);
        chk("last_cycle", 64'(last_cyc - cmt_cyc), 64'd577);
        chk("last_val", last_c1, 32'h0000_033F);

        for (int t = 0; t < 4; t++) begin
            rmode = tv[t].rmode;
            fill(tv[t].desc, tv[t].base, 1'b0, N);
            commit_push();
            wait_drain(6000);
            chk("vec_first", first_c1, tv[t].exp0);
            chk("vec_last", last_c1, tv[t].exp575);
        end
        rmode = 0;
        chk("no_overflow", overflow, 1'b0);

        // Ping-pong: granule A must land in bank 1 so out-of-range writes would alias onto it.
        if (mbank == 0) begin
            fill(1'b0, 32'h0000_0A00, 1'b0, N);
            commit_push();
            wait_drain(3000);
        end
        rmode = 2;
        repeat (2) @(posedge clk);
        #1;
        fill(1'b0, 32'h0000_5000, 1'b0, N);
        commit_push();
        wr_v = 1'b1; wr_pos_in = 10'd600; ch1_in = 32'hDEAD_BEEF; ch2_in = 32'hDEAD_BEEF;
        @(posedge clk); #1 wr_pos_in = 10'd1023;
        @(posedge clk); #1 wr_v = 1'b0;
        fill(1'b1, 32'h0000_6000, 1'b0, N);
        commit_push();
        @(negedge clk);
        chk("both_full_rdy", {wr_ready, overflow}, {1'b0, 1'b0});
        @(posedge clk); #1;
        wr_commit = 1'b1; wr_v = 1'b1; wr_pos_in = 10'd5;
        @(posedge clk); #1;
        wr_commit = 1'b0; wr_v = 1'b0;
        @(negedge clk);
        chk("ovf_set", {overflow, wr_ready}, {1'b1, 1'b0});
        gap = -1;
        rmode = 0;
        wait_drain(4000);
        chk("pingpong_gap", 32'(gap), 32'd1);
        chk("ovf_sticky", overflow, 1'b1);

        // Partial granule after both banks hold 0xFFFF.
        fill(1'b0, 32'h0000_FFFF, 1'b1, N); commit_push(); wait_drain(3000);
        fill(1'b0, 32'h0000_FFFF, 1'b1, N); commit_push(); wait_drain(3000);
        fill(1'b0, 32'h0000_0007, 1'b1, 10); commit_push(); wait_drain(3000);
        chk("zf_head", first_c1, 32'h7);
        chk("zf_tail", last_c1, ZF ? 32'h0 : 32'h0000_FFFF);

        // Reset in the middle of a stream.
        fill(1'b0, 32'h0000_0300, 1'b0, N);
        commit_push();
        start = beat_cnt;
        i = 0;
        while ((beat_cnt - start) < 200 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk("reach_200", (beat_cnt - start) >= 200, 1'b1);
        #1 rst = 1'b1;
        sb.delete();
        mbank = 0;
        for (int b = 0; b < 2; b++) for (int p = 0; p < N; p++) mw[b][p] = 1'b0;
        @(negedge clk);
        chk("rst_mid", {dout_v, wr_ready, overflow, pos_out}, {1'b0, 1'b1, 1'b0, 10'd0});
        @(posedge clk); #1 rst = 1'b0;
        fill(1'b0, 32'h0000_0400, 1'b0, N);
        commit_push();
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("post_rst_first", {dout_v, pos_out}, {1'b1, 10'd0});
        wait_drain(3000);
        chk("post_rst_last", last_c1, 32'h0000_063F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
